ao486_avalon_burst_splitter: RTL and testbench



---
 rtl/ao486_avalon_burst_splitter.sv | 164 ++++++++++++++++
 tb/tb_ao486_avalon_burst_splitter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ao486_avalon_burst_splitter.sv
// rtl/ao486_avalon_burst_splitter.sv - splits ao486 Avalon bursts into single-word transactions
// Optional perf counters (perf_split_cnt, perf_stall_cnt) enabled by AO486_SPLIT_PERF_EN.
module ao486_avalon_burst_splitter #(
   parameter int ADDR_W    = 30,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] core_address,
   input  logic [31:0]       core_writedata,
   input  logic [3:0]        core_byteenable,
   input  logic [2:0]        core_burstcount,
   input  logic              core_read,
   input  logic              core_write,
   output logic              core_waitrequest,
   output logic              core_readdatavalid,
   output logic [31:0]       core_readdata,
   output logic [ADDR_W-1:0] dn_address,
   output logic [31:0]       dn_writedata,
   output logic [3:0]        dn_byteenable,
   output logic [2:0]        dn_burstcount,
   output logic              dn_read,
   output logic              dn_write,
   input  logic              dn_waitrequest,
   input  logic              dn_readdatavalid,
   input  logic [31:0]       dn_readdata
`ifdef AO486_SPLIT_PERF_EN
   ,
   output logic [15:0]       perf_split_cnt,
   output logic [15:0]       perf_stall_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, RD_ACK, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0]        be_q, be_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic              rdv_q, rdv_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [2:0]        burst_cnt;

   // A zero burstcount still moves one word; oversize bursts are clamped.
   always_comb begin
      burst_cnt = core_burstcount;
      if (core_burstcount == 3'd0)
         burst_cnt = 3'd1;
      else if (core_burstcount > 3'(MAX_BURST))
         burst_cnt = 3'(MAX_BURST);
   end

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      be_d             = be_q;
      cnt_d            = cnt_q;
      idx_d            = idx_q;
      rdv_d            = 1'b0;
      rdata_d          = rdata_q;
      core_waitrequest = 1'b1;
      dn_read          = 1'b0;
      dn_write         = 1'b0;
      dn_byteenable    = be_q;
      case (state_q)
         IDLE: begin
            if (core_read) begin
               base_d  = core_address;
               be_d    = core_byteenable;
               cnt_d   = burst_cnt;
               idx_d   = 3'd0;
               state_d = RD_ACK;
            end else if (core_write) begin
               base_d  = core_address;
               cnt_d   = burst_cnt;
               idx_d   = 3'd0;
               state_d = WR_ISSUE;
            end
         end
         RD_ACK: begin
            core_waitrequest = 1'b0;
            state_d          = RD_ISSUE;
         end
         RD_ISSUE: begin
            dn_read = 1'b1;
            if (!dn_waitrequest)
               state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (dn_readdatavalid) begin
               rdv_d   = 1'b1;
               rdata_d = dn_readdata;
               idx_d   = idx_q + 3'd1;
               state_d = (idx_q + 3'd1 == cnt_q) ? IDLE : RD_ISSUE;
            end
         end
         WR_ISSUE: begin
            // Write beats flow straight through; the core stalls on the transducer.
            dn_write         = core_write;
            dn_byteenable    = core_byteenable;
            core_waitrequest = dn_waitrequest;
            if (core_write && !dn_waitrequest) begin
               idx_d = idx_q + 3'd1;
               if (idx_q + 3'd1 == cnt_q)
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dn_address         = base_q + ADDR_W'(idx_q);
   assign dn_writedata       = core_writedata;
   assign dn_burstcount      = 3'd1;
   assign core_readdatavalid = rdv_q;
   assign core_readdata      = rdata_q;

`ifdef AO486_SPLIT_PERF_EN
   logic [15:0] split_q, split_d, stall_q, stall_d;

   always_comb begin
      split_d = split_q;
      stall_d = stall_q;
      if (state_q == IDLE && (state_d == RD_ACK || state_d == WR_ISSUE) &&
          burst_cnt > 3'd1 && split_q != 16'hFFFF)
         split_d = split_q + 16'd1;
      if ((dn_read || dn_write) && dn_waitrequest && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   assign perf_split_cnt = split_q;
   assign perf_stall_cnt = stall_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         be_q    <= 4'd0;
         cnt_q   <= 3'd0;
         idx_q   <= 3'd0;
         rdv_q   <= 1'b0;
         rdata_q <= 32'd0;
`ifdef AO486_SPLIT_PERF_EN
         split_q <= 16'd0;
         stall_q <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rdv_q   <= rdv_d;
         rdata_q <= rdata_d;
`ifdef AO486_SPLIT_PERF_EN
         split_q <= split_d;
         stall_q <= stall_d;
`endif
      end
   end

endmodule

// File: tb/tb_ao486_avalon_burst_splitter.sv
// tb/tb_ao486_avalon_burst_splitter.sv - self-checking bench for ao486_avalon_burst_splitter
// Perf counter checks are compiled in when AO486_SPLIT_PERF_EN is defined.
module tb_ao486_avalon_burst_splitter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] core_address = '0;
   logic [31:0] core_writedata = '0;
   logic [3:0]  core_byteenable = '0;
   logic [2:0]  core_burstcount = '0;
   logic        core_read = 1'b0;
   logic        core_write = 1'b0;
   logic        core_waitrequest;
   logic        core_readdatavalid;
   logic [31:0] core_readdata;
   logic [29:0] dn_address;
   logic [31:0] dn_writedata;
   logic [3:0]  dn_byteenable;
   logic [2:0]  dn_burstcount;
   logic        dn_read;
   logic        dn_write;
   logic        dn_waitrequest = 1'b1;
   logic        dn_readdatavalid = 1'b0;
   logic [31:0] dn_readdata = '0;
`ifdef AO486_SPLIT_PERF_EN
   logic [15:0] perf_split_cnt;
   logic [15:0] perf_stall_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int stall_model = 0;

   always #5 clk = ~clk;

   ao486_avalon_burst_splitter #(.ADDR_W(30), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_address(core_address), .core_writedata(core_writedata),
      .core_byteenable(core_byteenable), .core_burstcount(core_burstcount),
      .core_read(core_read), .core_write(core_write),
      .core_waitrequest(core_waitrequest), .core_readdatavalid(core_readdatavalid),
      .core_readdata(core_readdata),
      .dn_address(dn_address), .dn_writedata(dn_writedata),
      .dn_byteenable(dn_byteenable), .dn_burstcount(dn_burstcount),
      .dn_read(dn_read), .dn_write(dn_write),
      .dn_waitrequest(dn_waitrequest), .dn_readdatavalid(dn_readdatavalid),
      .dn_readdata(dn_readdata)
`ifdef AO486_SPLIT_PERF_EN
      , .perf_split_cnt(perf_split_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clamp_beats(input logic [2:0] bc);
      if (bc == 3'd0) return 1;
      if (bc > 3'd4) return 4;
      return int'(bc);
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_waitreq"}, core_waitrequest, 1);
      chk({tag, "_rdv"}, core_readdatavalid, 0);
      chk({tag, "_rdata"}, core_readdata, 0);
      chk({tag, "_dn_read"}, dn_read, 0);
      chk({tag, "_dn_write"}, dn_write, 0);
      chk({tag, "_dn_addr"}, dn_address, 0);
   endtask

   task automatic check_quiet(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("quiet_dn_read", dn_read, 0);
         chk("quiet_dn_write", dn_write, 0);
         chk("quiet_core_rdv", core_readdatavalid, 0);
      end
   endtask

   task automatic core_cmd_read(input logic [29:0] addr, input logic [2:0] bc,
                                input logic [3:0] be, input bit both);
      bit got;
      got = 1'b0;
      core_address = addr; core_burstcount = bc; core_byteenable = be;
      core_read = 1'b1; core_write = both;
      #1 chk("idle_waitreq", core_waitrequest, 1);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (!core_waitrequest) begin got = 1'b1; break; end
      end
      chk("rd_cmd_accept", got, 1);
      @(negedge clk);
      core_read = 1'b0; core_write = 1'b0;
   endtask

   task automatic serve_read_beat(input logic [29:0] exp_addr, input logic [3:0] be,
                                  input int w, input int lat, input bit stray,
                                  input logic [31:0] data);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (dn_read) begin got = 1'b1; break; end
         @(negedge clk);
      end
      chk("rd_issue_seen", got, 1);
      chk("rd_addr", dn_address, exp_addr);
      chk("rd_burstcount", dn_burstcount, 1);
      chk("rd_be", dn_byteenable, be);
      chk("rd_no_write", dn_write, 0);
      dn_waitrequest = 1'b1;
      for (int k = 0; k < w; k++) begin
         dn_readdatavalid = stray;
         dn_readdata = 32'hDEAD0000 | k;
         @(negedge clk);
         dn_readdatavalid = 1'b0;
         stall_model++;
         chk("rd_hold_read", dn_read, 1);
         chk("rd_hold_addr", dn_address, exp_addr);
         chk("rd_stray_ignored", core_readdatavalid, 0);
      end
      dn_waitrequest = 1'b0;
      @(negedge clk);
      dn_waitrequest = 1'b1;
      chk("rd_one_outstanding", dn_read, 0);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         chk("rd_no_early_beat", core_readdatavalid, 0);
      end
      dn_readdatavalid = 1'b1;
      dn_readdata = data;
      @(negedge clk);
      dn_readdatavalid = 1'b0;
      dn_readdata = $urandom;
      chk("rd_beat_valid", core_readdatavalid, 1);
      chk("rd_beat_data", core_readdata, data);
   endtask

   task automatic do_read(input logic [29:0] addr, input logic [2:0] bc, input logic [3:0] be,
                          input int w_sel, input int lat_sel, input bit stray, input bit both,
                          input bit rnd, input logic [31:0] d0);
      int n, w, lat;
      logic [31:0] d;
      logic [29:0] a;
      n = clamp_beats(bc);
      core_cmd_read(addr, bc, be, both);
      for (int i = 0; i < n; i++) begin
         w   = (w_sel < 0) ? int'($urandom_range(3, 0)) : w_sel;
         lat = (lat_sel < 0) ? int'($urandom_range(2, 0)) : lat_sel;
         d   = rnd ? $urandom : d0 + 32'(i);
         a   = addr + 30'(i);
         serve_read_beat(a, be, w, lat, stray, d);
      end
      check_quiet(3);
   endtask

   task automatic do_write(input logic [29:0] addr, input logic [2:0] bc, input logic [3:0] be,
                           input int w_sel, input bit pause_en, input bit rnd,
                           input logic [31:0] d0);
      int n, w;
      bit got;
      logic [31:0] d [4];
      logic [29:0] a;
      n = clamp_beats(bc);
      for (int i = 0; i < 4; i++) d[i] = rnd ? $urandom : d0 * 32'(i + 1);
      core_address = addr; core_burstcount = bc; core_byteenable = be;
      core_write = 1'b1; core_writedata = d[0]; dn_waitrequest = 1'b1;
      #1 chk("wr_idle_waitreq", core_waitrequest, 1);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && pause_en && $urandom_range(1, 0) == 1) begin
            core_write = 1'b0;
            #1 chk("wr_pause_nowrite", dn_write, 0);
            @(negedge clk);
            core_write = 1'b1;
         end
         core_writedata = d[i];
         a = addr + 30'(i);
         got = 1'b0;
         for (int k = 0; k < 16; k++) begin
            #1;
            if (dn_write) begin got = 1'b1; break; end
            @(negedge clk);
         end
         chk("wr_issue_seen", got, 1);
         w = (w_sel < 0) ? int'($urandom_range(2, 0)) : w_sel;
         dn_waitrequest = 1'b1;
         for (int k = 0; k < w; k++) begin
            #1 chk("wr_stall_waitreq", core_waitrequest, 1);
            chk("wr_stall_hold", dn_write, 1);
            @(negedge clk);
            stall_model++;
         end
         dn_waitrequest = 1'b0;
         #1;
         chk("wr_addr", dn_address, a);
         chk("wr_data", dn_writedata, d[i]);
         chk("wr_be", dn_byteenable, be);
         chk("wr_burstcount", dn_burstcount, 1);
         chk("wr_no_read", dn_read, 0);
         chk("wr_core_accept", core_waitrequest, 0);
         @(negedge clk);
      end
      core_write = 1'b0;
      dn_waitrequest = 1'b1;
      #1 chk("wr_done_waitreq", core_waitrequest, 1);
      check_quiet(2);
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [29:0] ra;
      logic [2:0]  rbc;
      int          op;

      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);

      do_read(30'h100, 3'd4, 4'hF, 0, 1, 1'b0, 1'b0, 1'b0, 32'hA0);
      do_read(30'h2A0, 3'd1, 4'h3, 5, 0, 1'b1, 1'b0, 1'b1, 32'h0);
      do_write(30'h3FFFFFFF, 3'd2, 4'hF, 0, 1'b0, 1'b0, 32'h11);
      do_read(30'h40, 3'd7, 4'hF, -1, -1, 1'b0, 1'b0, 1'b1, 32'h0);
      do_read(30'h500, 3'd0, 4'hC, -1, -1, 1'b0, 1'b1, 1'b1, 32'h0);

      core_cmd_read(30'h2000, 3'd4, 4'hF, 1'b0);
      serve_read_beat(30'h2000, 4'hF, 0, 1, 1'b0, 32'hCAFE0001);
      for (int k = 0; k < 16 && !dn_read; k++) @(negedge clk);
      chk("rst_beat1_addr", dn_address, 30'h2001);
      dn_waitrequest = 1'b0;
      @(negedge clk);
      dn_waitrequest = 1'b1;
      rst_n = 1'b0;
      #1 check_reset_values("midburst_reset");
      @(negedge clk);
      rst_n = 1'b1;
      dn_readdatavalid = 1'b1;
      dn_readdata = 32'hBAD0BAD0;
      @(negedge clk);
      dn_readdatavalid = 1'b0;
      chk("late_rdv_ignored", core_readdatavalid, 0);
      chk("late_rdata_ignored", core_readdata, 0);
      check_quiet(3);
      do_read(30'h777, 3'd1, 4'hF, -1, -1, 1'b0, 1'b0, 1'b1, 32'h0);

      for (int it = 0; it < 24; it++) begin
         op  = int'($urandom_range(2, 0));
         rbc = 3'($urandom_range(7, 0));
         ra  = ($urandom_range(3, 0) == 0) ? 30'h3FFFFFFC + 30'($urandom_range(3, 0))
                                           : 30'($urandom);
         if (op == 2)
            do_write(ra, rbc, 4'($urandom), -1, 1'b1, 1'b1, 32'h0);
         else
            do_read(ra, rbc, 4'($urandom), -1, -1, 1'($urandom), 1'(op), 1'b1, 32'h0);
      end

`ifdef AO486_SPLIT_PERF_EN
      rst_n = 1'b0;
      #1;
      chk("perf_split_reset", perf_split_cnt, 0);
      chk("perf_stall_reset", perf_stall_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      stall_model = 0;
      for (int b = 0; b < 3; b++)
         do_read(30'h800 + 30'(b * 8), 3'd4, 4'hF, -1, -1, 1'b0, 1'b0, 1'b1, 32'h0);
      do_read(30'h900, 3'd1, 4'hF, 2, 0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("perf_split_cnt", perf_split_cnt, 3);
      chk("perf_stall_cnt", perf_stall_cnt, 32'(stall_model));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
